// File: rtl/retire_stage_pkg.sv
// retire_stage_pkg: shared widths, retire packet, FSM state and helpers for the retire stage.
package retire_stage_pkg;
  localparam int RETIRE_W = 3;
  localparam int ARCH_REGS = 32;
  localparam int ARCH_REG_W = 5;
  localparam int PR = 6;
  typedef logic [PR-1:0] preg_t;
  typedef struct packed {
    logic valid;
    logic complete;
    logic has_dest;
    logic [ARCH_REG_W-1:0] arch_dest;
    preg_t tnew;
    preg_t told;
    logic mispredict;
    logic halt;
  } ROB_RETIRE_PACKET;
  typedef enum logic {RUN, HALTED} RETIRE_STATE;
  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction
endpackage

// File: rtl/retire_stage_if.sv
// retire_stage_if: ROB-head entries offered to the retire stage and the per-slot pop strobe back.
interface retire_stage_if;
  import retire_stage_pkg::*;
  logic [RETIRE_W-1:0] rob_valid;
  logic [RETIRE_W-1:0] rob_complete;
  logic [RETIRE_W-1:0] rob_has_dest;
  logic [RETIRE_W-1:0][ARCH_REG_W-1:0] rob_arch_dest;
  preg_t [RETIRE_W-1:0] rob_tnew;
  preg_t [RETIRE_W-1:0] rob_told;
  logic [RETIRE_W-1:0] rob_mispredict;
  logic [RETIRE_W-1:0] rob_halt;
  logic [RETIRE_W-1:0] rob_retire;
  modport master (
    output rob_valid, rob_complete, rob_has_dest, rob_arch_dest, rob_tnew, rob_told,
           rob_mispredict, rob_halt,
    input  rob_retire
  );
  modport slave (
    input  rob_valid, rob_complete, rob_has_dest, rob_arch_dest, rob_tnew, rob_told,
           rob_mispredict, rob_halt,
    output rob_retire
  );
endinterface

// File: rtl/retire_stage_arch_map_table.sv
// arch_map_table: architectural map table with ordered 3-port write (slot 2 first) and next-state output.
module arch_map_table
  import retire_stage_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic [RETIRE_W-1:0] we,
  input  logic [RETIRE_W-1:0][ARCH_REG_W-1:0] waddr,
  input  preg_t [RETIRE_W-1:0] wdata,
  output preg_t [ARCH_REGS-1:0] amt_next
);
  preg_t [ARCH_REGS-1:0] amt;
  // Younger slots are applied last so they win on a shared destination.
  always_comb begin
    amt_next = amt;
    for (int k = RETIRE_W - 1; k >= 0; k--)
      if (we[k]) amt_next[waddr[k]] = wdata[k];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < ARCH_REGS; i++) amt[i] <= PR'(i);
    else amt <= amt_next;
endmodule

// File: rtl/retire_stage.sv
// retire_stage: in-order 3-wide commit; drives ROB pops, free-list returns, recovery strobe and the AMT.
// Optional RETIRE_STATS_EN adds retired_cnt / mispredict_cnt counters.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  retire_stage_if.slave rob,
  output logic [RETIRE_W-1:0] RetireEN,
  output preg_t [RETIRE_W-1:0] RetireReg,
  output logic BPRecoverEN,
  output preg_t [ARCH_REGS-1:0] amt_recover,
  output logic halted
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [15:0] mispredict_cnt
`endif
);
  RETIRE_STATE state;
  ROB_RETIRE_PACKET pkt [RETIRE_W];
  logic [RETIRE_W-1:0] retire;
  logic go, halt_ret;
  // Walk oldest to youngest; go drops at the first slot that cannot retire or ends the group.
  always_comb begin
    go = reset_n && state == RUN;
    retire = '0;
    RetireEN = '0;
    RetireReg = '0;
    BPRecoverEN = 1'b0;
    halt_ret = 1'b0;
    for (int k = RETIRE_W - 1; k >= 0; k--) begin
      pkt[k] = {rob.rob_valid[k], rob.rob_complete[k], rob.rob_has_dest[k], rob.rob_arch_dest[k],
                rob.rob_tnew[k], rob.rob_told[k], rob.rob_mispredict[k], rob.rob_halt[k]};
      retire[k] = go & pkt[k].valid & pkt[k].complete;
      go = retire[k] & ~pkt[k].mispredict & ~pkt[k].halt;
      RetireEN[k] = retire[k] & pkt[k].has_dest & (|pkt[k].arch_dest);
      RetireReg[k] = RetireEN[k] ? pkt[k].told : '0;
      BPRecoverEN = BPRecoverEN | (retire[k] & pkt[k].mispredict & ~pkt[k].halt);
      halt_ret = halt_ret | (retire[k] & pkt[k].halt);
    end
  end
  assign rob.rob_retire = retire;
  arch_map_table u_amt (
    .clock(clock),
    .reset_n(reset_n),
    .we(RetireEN),
    .waddr(rob.rob_arch_dest),
    .wdata(rob.rob_tnew),
    .amt_next(amt_recover)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= RUN;
      halted <= 1'b0;
    end else if (state == RUN && halt_ret) begin
      state <= HALTED;
      halted <= 1'b1;
    end
`ifdef RETIRE_STATS_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      retired_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      retired_cnt <= retired_cnt + 32'(popcnt3(retire));
      mispredict_cnt <= mispredict_cnt + 16'(BPRecoverEN);
    end
`endif
endmodule
